// File: rtl/psum_pkg.sv
// Shared constants and types for the partial-sum readout path.
// Holds the default geometry, the signed psum word type and the serializer state encoding.
// No logic; imported by psum_vec_fifo, psum_readout and the bench.
package psum_pkg;

    localparam int COL_DEFAULT     = 8;
    localparam int BW_PSUM_DEFAULT = 20;

    // One signed partial-sum word at the default width (2*bw+4).
    typedef logic signed [BW_PSUM_DEFAULT-1:0] psum_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/psum_vec_fifo.sv
// Circular FIFO of whole psum vectors, depth entries of width bits.
// Latency: a push is visible at pop_dat/empty the edge after it is written.
// Backpressure: a push into a full FIFO is accepted only when a pop happens on the same edge.
//
// Ports: clk/reset (async active-high), push/push_dat (write tail), pop (read head,
// ignored when empty), pop_dat (current head), full/empty, count (entries held).
module psum_vec_fifo #(
    parameter int width = 160,
    parameter int depth = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [width-1:0]           push_dat,
    input  logic                       pop,
    output logic [width-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth):0]     count
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // A full FIFO still takes the write when the head leaves on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        // depth is a power of two, so the pointers wrap by natural overflow.
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/psum_readout.sv
// Captures core psum vectors into a vector FIFO and serializes them one column per beat.
// Latency: capture at edge N into an idle path gives out_valid with column col-1 after edge N+1.
// Backpressure: out_ready stalls the serializer; the core cannot be stalled, so a capture into a full FIFO is dropped and sets sticky overflow.
//
// Ports: clk, reset (async active-high), capture/core_out (vector strobe and data,
// column q at [q*bw_psum +: bw_psum]), out_data/out_col/out_valid/out_ready/out_last
// (beat stream, column col-1 first, out_last on column 0), fifo_count (vectors queued
// behind the serializer), overflow (sticky drop flag).
// Build option: define PSUM_RELU_EN to clamp negative words to 0 as a vector is loaded.
module psum_readout
    import psum_pkg::*;
#(
    parameter int col     = COL_DEFAULT,
    parameter int bw_psum = BW_PSUM_DEFAULT,
    parameter int depth   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        capture,
    input  logic [bw_psum*col-1:0]      core_out,
    output logic [bw_psum-1:0]          out_data,
    output logic [$clog2(col)-1:0]      out_col,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [$clog2(depth):0]      fifo_count,
    output logic                        overflow
);

    localparam int CIW = $clog2(col);
    localparam int VW  = bw_psum * col;
    localparam logic [CIW-1:0] COL_LAST = CIW'(col - 1);

    state_t          state_q, state_d;
    logic [VW-1:0]   shift_q, shift_d;
    logic [CIW-1:0]  col_q, col_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;

    logic [VW-1:0]   head_vec;
    logic [VW-1:0]   load_vec;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            xfer;
    logic            final_beat;

    psum_vec_fifo #(
        .width (VW),
        .depth (depth)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (capture),
        .push_dat (core_out),
        .pop      (fifo_pop),
        .pop_dat  (head_vec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        load_vec = head_vec;
`ifdef PSUM_RELU_EN
        for (int q = 0; q < col; q++) begin
            if (head_vec[q*bw_psum + bw_psum - 1]) begin
                load_vec[q*bw_psum +: bw_psum] = '0;
            end
        end
`endif
    end

    assign xfer       = valid_q && out_ready;
    assign final_beat = xfer && (col_q == '0);
    // Reload straight from the FIFO on the final beat so vectors stream without a bubble.
    assign fifo_pop   = !fifo_empty && ((state_q == IDLE) || final_beat);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        col_d   = col_q;
        valid_d = valid_q;
        ovf_d   = ovf_q | (capture && fifo_full && !fifo_pop);
        if (fifo_pop) begin
            shift_d = load_vec;
            col_d   = COL_LAST;
            valid_d = 1'b1;
            state_d = SEND;
        end else if (final_beat) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end else if (xfer) begin
            // The current word always sits in the top slot; shift the next lower column up.
            shift_d = shift_q << bw_psum;
            col_d   = col_q - CIW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data  = shift_q[(col-1)*bw_psum +: bw_psum];
    assign out_col   = col_q;
    assign out_valid = valid_q;
    assign out_last  = valid_q && (col_q == '0);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_psum_readout.sv
// Self-checking bench for psum_readout: table-driven single vector, hand-written
// backpressure / back-to-back / overflow / reset sequences, then randomized traffic
// against a queue-based model of vectors waiting and the vector being serialized.
module tb_psum_readout;
    import psum_pkg::*;

    localparam int COL   = 8;
    localparam int BW    = 20;
    localparam int DEPTH = 4;

    logic                 clk;
    logic                 reset;
    logic                 capture;
    logic [BW*COL-1:0]    core_out;
    logic [BW-1:0]        out_data;
    logic [2:0]           out_col;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [2:0]           fifo_count;
    logic                 overflow;

    int checks = 0;
    int errors = 0;

    // Model: vectors waiting, plus the vector on the wire and which column is showing.
    logic [BW*COL-1:0] mq [$];
    bit                m_busy;
    logic [BW*COL-1:0] m_vec;
    int                m_idx;
    bit                m_ovf;

    psum_readout #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .core_out   (core_out),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic psum_t exp_word(input logic [BW*COL-1:0] v, input int q);
        psum_t w;
        w = v[q*BW +: BW];
`ifdef PSUM_RELU_EN
        if (w < 0) w = '0;
`endif
        return w;
    endfunction

    function automatic int relu_i(input int v);
`ifdef PSUM_RELU_EN
        if (v < 0) return 0;
`endif
        return v;
    endfunction

    function automatic logic [BW*COL-1:0] rand_vec();
        logic [BW*COL-1:0] v;
        for (int q = 0; q < COL; q++) v[q*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 0;
        m_idx  = 0;
        m_ovf  = 0;
        m_vec  = '0;
    endtask

    // One clock edge of the model, from the inputs seen at that edge.
    task automatic model_edge(input bit cap, input logic [BW*COL-1:0] vec, input bit rdy);
        bit xfer, fin, pop, push_ok;
        xfer    = m_busy && rdy;
        fin     = xfer && (m_idx == 0);
        pop     = (mq.size() > 0) && (!m_busy || fin);
        push_ok = cap && ((mq.size() < DEPTH) || pop);
        if (cap && !push_ok) m_ovf = 1;
        if (pop) begin
            m_vec  = mq.pop_front();
            m_idx  = COL - 1;
            m_busy = 1;
        end else if (fin) begin
            m_busy = 0;
        end else if (xfer) begin
            m_idx--;
        end
        if (push_ok) mq.push_back(vec);
    endtask

    task automatic compare_model();
        chk("m_valid", out_valid, m_busy);
        chk("m_fifo_count", fifo_count, mq.size());
        chk("m_overflow", overflow, m_ovf);
        chk("m_last", out_last, (m_busy && m_idx == 0));
        if (m_busy) begin
            chk("m_col", out_col, m_idx);
            chk("m_data", $signed(out_data), exp_word(m_vec, m_idx));
        end
    endtask

    task automatic step(input bit cap, input logic [BW*COL-1:0] vec, input bit rdy);
        capture   = cap;
        core_out  = vec;
        out_ready = rdy;
        @(posedge clk);
        model_edge(cap, vec, rdy);
        #1;
        compare_model();
    endtask

    task automatic hw_reset();
        capture = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit cap;
        bit rdy;
        bit e_vld;
        int e_dat;
        int e_col;
        bit e_last;
    } row_t;

    initial begin
        logic [BW*COL-1:0] pat;
        logic [BW*COL-1:0] va, vb, vc;
        row_t tbl [10];
        psum_t got [$];
        int first_v, last_v, nvalid, peak, nlast;

        for (int q = 0; q < COL; q++) pat[q*BW +: BW] = BW'(q*100 - 350);

        // Reset state
        reset     = 1'b1;
        capture   = 1'b0;
        out_ready = 1'b0;
        core_out  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_col", out_col, 0);
        chk("rst_last", out_last, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;

        // Single vector, table driven
        tbl[0].cap = 1; tbl[0].rdy = 1; tbl[0].e_vld = 0; tbl[0].e_dat = 0; tbl[0].e_col = 0; tbl[0].e_last = 0;
        for (int i = 1; i <= 8; i++) begin
            tbl[i].cap    = 0;
            tbl[i].rdy    = 1;
            tbl[i].e_vld  = 1;
            tbl[i].e_col  = 8 - i;
            tbl[i].e_dat  = relu_i((8 - i)*100 - 350);
            tbl[i].e_last = (i == 8);
        end
        tbl[9].cap = 0; tbl[9].rdy = 1; tbl[9].e_vld = 0; tbl[9].e_dat = 0; tbl[9].e_col = 0; tbl[9].e_last = 0;
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].cap, pat, tbl[i].rdy);
            chk("tbl_valid", out_valid, tbl[i].e_vld);
            chk("tbl_last", out_last, tbl[i].e_last);
            if (tbl[i].e_vld) begin
                chk("tbl_data", $signed(out_data), tbl[i].e_dat);
                chk("tbl_col", out_col, tbl[i].e_col);
            end
        end

        // Backpressure: ready pattern 1,0,0,1 repeating
        step(1, pat, 0);
        for (int i = 0; i < 40; i++) begin
            bit r, stalled;
            logic [BW-1:0] pd;
            logic [2:0] pc;
            r       = (i % 4 == 0) || (i % 4 == 3);
            stalled = out_valid && !r;
            pd      = out_data;
            pc      = out_col;
            if (out_valid && r) got.push_back(out_data);
            step(0, pat, r);
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
                chk("hold_col", out_col, pc);
            end
        end
        chk("bp_beats", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++) chk("bp_order", got[k], relu_i(350 - 100*k));

        // Back-to-back captures, contiguous 24 beats
        va = rand_vec(); vb = rand_vec(); vc = rand_vec();
        first_v = -1; last_v = -1; nvalid = 0; peak = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) step(1, va, 1);
            else if (i == 1) step(1, vb, 1);
            else if (i == 2) step(1, vc, 1);
            else step(0, va, 1);
            if (out_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                nvalid++;
            end
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        chk("b2b_beats", nvalid, 24);
        chk("b2b_contiguous", last_v - first_v + 1, 24);
        chk("b2b_peak_count", peak, 2);
        chk("b2b_final_count", fifo_count, 0);

        // Overflow: 6 captures with the sink stalled
        hw_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, rand_vec(), 0);
            if (i == 4) begin
                chk("ovf_before", overflow, 0);
                chk("ovf_count_full", fifo_count, 4);
            end
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_count", fifo_count, 4);
        nlast = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid && out_last) nlast++;
            step(0, pat, 1);
        end
        chk("ovf_vectors_out", nlast, 5);
        chk("ovf_sticky", overflow, 1);

        // Reset mid-stream during beat 3 with 2 vectors queued
        hw_reset();
        step(1, rand_vec(), 1);
        step(1, rand_vec(), 1);
        step(1, rand_vec(), 1);
        step(0, pat, 1);
        chk("mid_col", out_col, 5);
        chk("mid_count", fifo_count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_last", out_last, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, pat, 1);
            chk("post_rst_idle", out_valid, 0);
        end

        // Randomized traffic: light load, then overload, then drain
        hw_reset();
        for (int i = 0; i < 400; i++) step($urandom_range(0, 11) == 0, rand_vec(), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 200; i++) step($urandom_range(0, 2) == 0, rand_vec(), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 60; i++) step(0, pat, 1);
        chk("rand_drained_valid", out_valid, 0);
        chk("rand_drained_count", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
